// File: rtl/text_buffer_ctrl_if.sv
// Host write-request channel into text_buffer_ctrl: valid/ready handshake carrying a cell
// address and character code. The controller takes the slave modport.
interface text_buffer_ctrl_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned CHAR_W = 12
);
   logic              host_valid;
   logic              host_ready;
   logic [ADDR_W-1:0] host_addr;
   logic [CHAR_W-1:0] host_data;

   modport master (
      output host_valid,
      output host_addr,
      output host_data,
      input  host_ready
   );

   modport slave (
      input  host_valid,
      input  host_addr,
      input  host_data,
      output host_ready
   );
endinterface

// File: rtl/text_buffer_ctrl.sv
// Write-port controller for the 80x30 text buffer: arbitrates host writes against a fill engine.
// Define TEXT_BUFFER_CTRL_FILL_RANGE_EN to restrict the fill to a fill_first_i..fill_last_i range.
module text_buffer_ctrl #(
   parameter int unsigned CHARACTER_SET_COUNT = 2400,
   parameter int unsigned BUF_DEPTH           = 2400,
   localparam int unsigned CHAR_W = $clog2(CHARACTER_SET_COUNT),
   localparam int unsigned ADDR_W = $clog2(BUF_DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   text_buffer_ctrl_if.slave   host_io,
   input  logic                fill_start_i,
   input  logic [CHAR_W-1:0]   fill_char_i,
`ifdef TEXT_BUFFER_CTRL_FILL_RANGE_EN
   input  logic [ADDR_W-1:0]   fill_first_i,
   input  logic [ADDR_W-1:0]   fill_last_i,
`endif
   output logic                busy_o,
   output logic                fill_done_o,
   output logic                addr_err_o,
   output logic                buf_en_o,
   output logic                buf_we_o,
   output logic [ADDR_W-1:0]   buf_waddr_o,
   output logic [CHAR_W-1:0]   buf_wdata_o
);

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(BUF_DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [CHAR_W-1:0] char_q, char_d;
   logic              buf_en_q;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [CHAR_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;
   logic              host_ready;
   logic [ADDR_W-1:0] fill_first;
   logic [ADDR_W-1:0] fill_last_lim;
   logic              range_ok;

`ifdef TEXT_BUFFER_CTRL_FILL_RANGE_EN
   logic [ADDR_W-1:0] last_q, last_d;

   assign fill_first    = fill_first_i;
   assign fill_last_lim = last_q;
   assign range_ok      = (fill_first_i <= fill_last_i) && (fill_last_i <= LastAddr);
`else
   assign fill_first    = '0;
   assign fill_last_lim = LastAddr;
   assign range_ok      = 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      char_d     = char_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      err_d      = 1'b0;
      host_ready = 1'b0;
`ifdef TEXT_BUFFER_CTRL_FILL_RANGE_EN
      last_d     = last_q;
`endif
      unique case (state_q)
         StIdle: begin
            // Nothing is accepted until the buffer enable has come up after reset.
            host_ready = buf_en_q && !fill_start_i;
            if (buf_en_q && fill_start_i) begin
               if (range_ok) begin
                  // The first fill write is issued straight from the start cycle.
                  state_d = StFill;
                  cnt_d   = fill_first;
                  char_d  = fill_char_i;
                  we_d    = 1'b1;
                  waddr_d = fill_first;
                  wdata_d = fill_char_i;
`ifdef TEXT_BUFFER_CTRL_FILL_RANGE_EN
                  last_d  = fill_last_i;
`endif
               end else begin
                  err_d = 1'b1;
               end
            end else if (host_io.host_valid && buf_en_q) begin
               if (host_io.host_addr > LastAddr) begin
                  err_d = 1'b1;
               end else begin
                  we_d    = 1'b1;
                  waddr_d = host_io.host_addr;
                  wdata_d = host_io.host_data;
               end
            end
         end
         StFill: begin
            // cnt_q is the address whose write is on the buffer port this cycle.
            if (cnt_q == fill_last_lim) begin
               state_d = StDone;
            end else begin
               cnt_d   = cnt_q + ADDR_W'(1);
               we_d    = 1'b1;
               waddr_d = cnt_q + ADDR_W'(1);
               wdata_d = char_q;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         char_q   <= '0;
         buf_en_q <= 1'b0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
`ifdef TEXT_BUFFER_CTRL_FILL_RANGE_EN
         last_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         char_q   <= char_d;
         buf_en_q <= 1'b1;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
`ifdef TEXT_BUFFER_CTRL_FILL_RANGE_EN
         last_q   <= last_d;
`endif
      end
   end

   assign host_io.host_ready = host_ready;
   assign busy_o             = (state_q == StFill);
   assign fill_done_o        = (state_q == StDone);
   assign addr_err_o         = err_q;
   assign buf_en_o           = buf_en_q;
   assign buf_we_o           = we_q;
   assign buf_waddr_o        = waddr_q;
   assign buf_wdata_o        = wdata_q;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Self-checking bench for text_buffer_ctrl: directed vector table, fill/reset sequences and
// random traffic checked against a cycle-schedule reference model.
module tb_text_buffer_ctrl;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned CHAR_W = 12;
   localparam int          DEPTH  = 2400;

   typedef struct packed {
      logic        ready;
      logic        busy;
      logic        done;
      logic        err;
      logic        en;
      logic        we;
      logic [11:0] waddr;
      logic [11:0] wdata;
   } out_t;

   typedef struct {
      bit          v;
      logic [11:0] a;
      logic [11:0] d;
      out_t        exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   text_buffer_ctrl_if #(.ADDR_W(ADDR_W), .CHAR_W(CHAR_W)) host_if ();

   logic              fill_start;
   logic [CHAR_W-1:0] fill_char;
   logic [ADDR_W-1:0] fill_first;
   logic [ADDR_W-1:0] fill_last;
   logic              busy, fill_done, addr_err, buf_en, buf_we;
   logic [ADDR_W-1:0] buf_waddr;
   logic [CHAR_W-1:0] buf_wdata;

   text_buffer_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .host_io      (host_if),
      .fill_start_i (fill_start),
      .fill_char_i  (fill_char),
`ifdef TEXT_BUFFER_CTRL_FILL_RANGE_EN
      .fill_first_i (fill_first),
      .fill_last_i  (fill_last),
`endif
      .busy_o       (busy),
      .fill_done_o  (fill_done),
      .addr_err_o   (addr_err),
      .buf_en_o     (buf_en),
      .buf_we_o     (buf_we),
      .buf_waddr_o  (buf_waddr),
      .buf_wdata_o  (buf_wdata)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a fill started in cycle s owns cycles s+1..s+n (writes), s+n+1 (done).
   int          cyc;
   int          fill_s;
   int          fill_n;
   int          fill_first_m;
   logic [11:0] fill_ch_m;
   bit          en_m, wr_prev, err_prev;
   logic [11:0] prev_a, prev_d, hold_a, hold_d;

   task automatic reset_model();
      cyc = 0; fill_s = -100000; fill_n = 0; fill_first_m = 0; fill_ch_m = '0;
      en_m = 0; wr_prev = 0; err_prev = 0;
      prev_a = '0; prev_d = '0; hold_a = '0; hold_d = '0;
   endtask

   function automatic out_t mk(bit r, bit b, bit dn, bit e, bit en, bit we,
                               logic [11:0] wa, logic [11:0] wd);
      out_t o;
      o.ready = r; o.busy = b; o.done = dn; o.err = e; o.en = en; o.we = we;
      o.waddr = wa; o.wdata = wd;
      return o;
   endfunction

   function automatic out_t model_out(bit fs);
      out_t o;
      bit   in_fill, done;
      in_fill = (cyc >= fill_s + 1) && (cyc <= fill_s + fill_n);
      done    = (cyc == fill_s + fill_n + 1);
      o.en    = en_m;
      o.busy  = in_fill;
      o.done  = done;
      o.ready = en_m && !in_fill && !done && !fs;
      o.err   = err_prev;
      if (in_fill) begin
         o.we = 1'b1; o.waddr = 12'(fill_first_m + cyc - fill_s - 1); o.wdata = fill_ch_m;
      end else if (wr_prev) begin
         o.we = 1'b1; o.waddr = prev_a; o.wdata = prev_d;
      end else begin
         o.we = 1'b0; o.waddr = hold_a; o.wdata = hold_d;
      end
      return o;
   endfunction

   function automatic out_t sample();
      return mk(host_if.host_ready, busy, fill_done, addr_err, buf_en, buf_we, buf_waddr,
                buf_wdata);
   endfunction

   task automatic check_out(string name, out_t got, out_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc %0d: got rdy=%b busy=%b done=%b err=%b en=%b we=%b addr=%0d data=%h, expected rdy=%b busy=%b done=%b err=%b en=%b we=%b addr=%0d data=%h",
                  name, cyc, got.ready, got.busy, got.done, got.err, got.en, got.we, got.waddr,
                  got.wdata, exp.ready, exp.busy, exp.done, exp.err, exp.en, exp.we, exp.waddr,
                  exp.wdata);
      end
   endtask

   task automatic check_int(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Called at posedge+1: drive, check at negedge, advance the model across the next edge.
   task automatic cycle(input bit v, input logic [11:0] a, input logic [11:0] d, input bit fs,
                        input logic [11:0] fc, input logic [11:0] ff, input logic [11:0] fl,
                        input bit use_tbl, input out_t texp, input string name,
                        output out_t got);
      out_t o;
      host_if.host_valid = v; host_if.host_addr = a; host_if.host_data = d;
      fill_start = fs; fill_char = fc; fill_first = ff; fill_last = fl;
      @(negedge clk);
      o   = model_out(fs);
      got = sample();
      check_out(name, got, use_tbl ? texp : o);
      @(posedge clk);
      hold_a   = o.waddr;
      hold_d   = o.wdata;
      wr_prev  = v && o.ready && (int'(a) < DEPTH);
      err_prev = v && o.ready && (int'(a) >= DEPTH);
      prev_a   = a;
      prev_d   = d;
      if (fs && en_m && !o.busy && !o.done) begin
`ifdef TEXT_BUFFER_CTRL_FILL_RANGE_EN
         if (ff <= fl && int'(fl) < DEPTH) begin
            fill_s = cyc; fill_first_m = int'(ff); fill_n = int'(fl) - int'(ff) + 1;
            fill_ch_m = fc;
         end else begin
            err_prev = 1'b1;
         end
`else
         fill_s = cyc; fill_first_m = 0; fill_n = DEPTH; fill_ch_m = fc;
`endif
      end
      en_m = 1'b1;
      cyc++;
      #1;
   endtask

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

   vec_t tbl[10];
   out_t got;
   out_t zero;

   initial begin
      int n_fill, n_done, n_err, accepted, after;
      bit hv;
      zero = '0;
      tbl[0] = '{1'b0, 12'd0,    12'h000, mk(0, 0, 0, 0, 0, 0, 12'd0,    12'h000)};
      tbl[1] = '{1'b1, 12'd5,    12'h041, mk(1, 0, 0, 0, 1, 0, 12'd0,    12'h000)};
      tbl[2] = '{1'b1, 12'd2399, 12'h07F, mk(1, 0, 0, 0, 1, 1, 12'd5,    12'h041)};
      tbl[3] = '{1'b1, 12'd2400, 12'h123, mk(1, 0, 0, 0, 1, 1, 12'd2399, 12'h07F)};
      tbl[4] = '{1'b0, 12'd0,    12'h000, mk(1, 0, 0, 1, 1, 0, 12'd2399, 12'h07F)};
      tbl[5] = '{1'b1, 12'd4095, 12'h001, mk(1, 0, 0, 0, 1, 0, 12'd2399, 12'h07F)};
      tbl[6] = '{1'b1, 12'd0,    12'h0AA, mk(1, 0, 0, 1, 1, 0, 12'd2399, 12'h07F)};
      tbl[7] = '{1'b0, 12'd0,    12'h000, mk(1, 0, 0, 0, 1, 1, 12'd0,    12'h0AA)};
      tbl[8] = '{1'b0, 12'd0,    12'h000, mk(1, 0, 0, 0, 1, 0, 12'd0,    12'h0AA)};
      tbl[9] = '{1'b1, 12'd2398, 12'hFFF, mk(1, 0, 0, 0, 1, 0, 12'd0,    12'h0AA)};

      host_if.host_valid = 1'b1; host_if.host_addr = '0; host_if.host_data = '0;
      fill_start = 1'b0; fill_char = '0; fill_first = '0; fill_last = '0;
      reset_model();
      #2;
      check_out("reset_values", sample(), zero);
      @(posedge clk); #1;
      rst_n = 1'b1;
      reset_model();

      for (int i = 0; i < 10; i++)
         cycle(tbl[i].v, tbl[i].a, tbl[i].d, 1'b0, '0, '0, '0, 1'b1, tbl[i].exp,
               $sformatf("vec%0d", i), got);
      cycle(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, zero, "post_table", got);

      // Full fill with a host request raised in the same cycle and held until it is served.
      n_fill = 0; n_done = 0; accepted = 0; after = -1; hv = 1'b1;
      cycle(1'b1, 12'd100, 12'h155, 1'b1, 12'h020, '0, '0, 1'b0, zero, "fill_start", got);
      for (int i = 0; i < 2600 && after < 1; i++) begin
         cycle(hv, 12'd100, 12'h155, (i == 500), 12'h0AB, '0, '0, 1'b0, zero, "fill", got);
         if (got.busy && got.we) n_fill++;
         if (got.done) n_done++;
         if (after >= 0) after++;
         if (hv && got.ready) begin hv = 1'b0; accepted++; after = 0; end
      end
      check_int("fill_writes", n_fill, DEPTH);
      check_int("fill_done_pulses", n_done, 1);
      check_int("host_accept_after_fill", accepted, 1);

      // Reset asserted while fill write 1000 is on the port.
      cycle(1'b0, '0, '0, 1'b1, 12'h0FF, '0, '0, 1'b0, zero, "fill2_start", got);
      for (int i = 0; i < 1000; i++)
         cycle(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, zero, "fill2", got);
      host_if.host_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1 check_out("reset_mid_fill", sample(), zero);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      reset_model();
      n_done = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, zero, "after_reset", got);
         if (got.done) n_done++;
      end
      check_int("no_done_after_reset", n_done, 0);

`ifdef TEXT_BUFFER_CTRL_FILL_RANGE_EN
      n_fill = 0;
      cycle(1'b0, '0, '0, 1'b1, 12'h02D, 12'd80, 12'd159, 1'b0, zero, "range_start", got);
      for (int i = 0; i < 85; i++) begin
         cycle(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, zero, "range_fill", got);
         if (got.we) n_fill++;
      end
      check_int("range_writes", n_fill, 80);
      n_fill = 0; n_err = 0;
      cycle(1'b0, '0, '0, 1'b1, 12'h02D, 12'd10, 12'd9, 1'b0, zero, "range_reject", got);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, zero, "range_reject_idle", got);
         if (got.we) n_fill++;
         if (got.err) n_err++;
      end
      check_int("range_reject_writes", n_fill, 0);
      check_int("range_reject_err", n_err, 1);
      n_fill = 0;
      cycle(1'b0, '0, '0, 1'b1, 12'h031, 12'd7, 12'd7, 1'b0, zero, "single_start", got);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, zero, "single_fill", got);
         if (got.we) n_fill++;
      end
      check_int("single_cell_writes", n_fill, 1);
`endif

      for (int i = 0; i < 3000; i++) begin
         logic [11:0] ra, rd, rf, rl;
         ra = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(2400, 4095))
                                          : 12'($urandom_range(0, 2399));
         rd = 12'($urandom_range(0, 4095));
         rf = 12'($urandom_range(0, 2399));
         rl = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095))
                                          : 12'(int'(rf) + int'($urandom_range(0, 30)));
         cycle(1'($urandom_range(0, 1)), ra, rd, ($urandom_range(0, 799) == 0),
               12'($urandom_range(0, 4095)), rf, rl, 1'b0, zero, "random", got);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/text_buffer_ctrl.md
Name: text_buffer_ctrl

Overview:
- Write-port controller for the 80x30 character text buffer.
- Shares the buffer's single write port between two requesters:
  - host character writes from the APB register block;
  - an internal fill engine that clears the whole buffer to one character code.
- Sits between the APB slave and the text buffer; the display read path is untouched.
- Generates registered write strobe, address and data, plus busy/done/error status.

Parameters:
- CHARACTER_SET_COUNT, 2400: number of distinct character codes; data width CHAR_W = $clog2(CHARACTER_SET_COUNT).
- BUF_DEPTH, 2400: number of buffer cells (80*30); address width ADDR_W = $clog2(BUF_DEPTH).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- host_valid_i  in  1  host write request.
- host_ready_o  out  1  host request accepted this cycle when valid & ready.
- host_addr_i  in  ADDR_W  host cell address.
- host_data_i  in  CHAR_W  host character code.
- fill_start_i  in  1  one-cycle pulse; starts buffer fill.
- fill_char_i  in  CHAR_W  fill character, sampled on accepted fill_start_i.
- busy_o  out  1  fill engine active.
- fill_done_o  out  1  one-cycle pulse after the last fill write.
- addr_err_o  out  1  one-cycle pulse: host address >= BUF_DEPTH was dropped.
- buf_en_o  out  1  buffer enable; low in reset, high afterwards.
- buf_we_o  out  1  buffer write enable.
- buf_waddr_o  out  ADDR_W  buffer write address.
- buf_wdata_o  out  CHAR_W  buffer write data.

Behaviour:
- Reset values:
  - all outputs 0, including host_ready_o and buf_en_o;
  - state IDLE; fill counter 0; latched fill char 0.
- buf_en_o goes to 1 on the first clock edge after reset release and stays 1.
- State machine:
  - IDLE -> FILL on fill_start_i.
  - FILL -> DONE on the last write (counter == BUF_DEPTH-1).
  - DONE -> IDLE unconditionally after one cycle.
- IDLE:
  - host_ready_o = 1 (combinational: state==IDLE and not fill_start_i).
  - Accepted host write: on the next cycle buf_we_o=1, buf_waddr_o=host_addr_i, buf_wdata_o=host_data_i. One-cycle registered latency.
  - Back-to-back accepted writes give one buffer write per cycle.
- Host address >= BUF_DEPTH:
  - accepted (handshake completes) but dropped: buf_we_o stays 0;
  - addr_err_o pulses on the following cycle.
- fill_start_i in IDLE:
  - latches fill_char_i and clears the counter;
  - wins over a simultaneous host_valid_i, which sees host_ready_o=0 and must hold its request.
- FILL:
  - host_ready_o=0; busy_o=1.
  - Each cycle issues buf_we_o=1, buf_waddr_o=counter, buf_wdata_o=latched char; counter increments.
  - Writes cover addresses 0..BUF_DEPTH-1, exactly BUF_DEPTH writes on consecutive cycles.
  - First write appears the cycle after fill_start_i.
- DONE:
  - busy_o drops to 0.
  - fill_done_o=1 for exactly one cycle, coinciding with the cycle after the last write.
  - host_ready_o=0 in DONE; host access resumes in the following IDLE cycle.
- fill_start_i while in FILL or DONE is ignored; there is no restart and no queueing.
- buf_we_o is 0 in any cycle with no accepted write. In those cycles buf_waddr_o and buf_wdata_o hold their previous values.
- Reset asserted mid-fill:
  - immediate return to reset values; partial fill is not resumed;
  - fill_done_o does not pulse.
- Counter width is ADDR_W; it never wraps past BUF_DEPTH-1.

Optional Feature:
- Macro: TEXT_BUFFER_CTRL_FILL_RANGE_EN.
- When defined:
  - adds inputs fill_first_i and fill_last_i (ADDR_W each), sampled with fill_start_i;
  - fill writes addresses fill_first_i..fill_last_i inclusive.
- Range rules:
  - If fill_first_i > fill_last_i or fill_last_i >= BUF_DEPTH: the fill is rejected, the state stays IDLE, and addr_err_o pulses once.
  - A single-cell range (first==last) gives one write, then DONE.
- When undefined: ports absent; the fill always covers 0..BUF_DEPTH-1.

Test Plan:
- Reset, then host writes (addr 5, data 0x041) and (addr 2399, data 0x07F) back-to-back -> buf_we_o high two consecutive cycles with matching addr/data; one-cycle latency.
- Host write to addr 2400 -> handshake completes, buf_we_o stays 0, addr_err_o pulses once.
- fill_start_i with fill_char_i=0x020 -> 2400 consecutive writes, addr 0..2399, data 0x020; busy_o high throughout; fill_done_o pulses one cycle after the last write.
- host_valid_i asserted during fill, and simultaneously with fill_start_i -> host_ready_o=0 until IDLE; the host write lands after fill_done_o with correct data; second fill_start_i mid-fill ignored.
- rst_n asserted at fill write 1000 -> all outputs 0 asynchronously; after release, IDLE with host_ready_o=1 and no fill_done_o pulse.
- With TEXT_BUFFER_CTRL_FILL_RANGE_EN: range 80..159 char 0x2D -> exactly 80 writes; range 10..9 -> no writes, addr_err_o pulse.
